// File: rtl/int_responder.sv
// Memory-mapped interrupt responder.
// Holds a small FIFO of programmed interrupt events. The oldest event is armed
// on a macroscopic-PC match, waits its programmed delay, then raises
// `interrupt`. The line stays high until the CPU stores to BASE_ADDR.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | queue empty, nothing to arm
//   S_ARMED  | head event waiting for macroscopic_pc == head.pc
//   S_DLY    | PC matched, counting down the head's delay
//   S_ASSERT | interrupt high, waiting for the handler's acknowledge store
module int_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
    parameter int          DEPTH     = 4,
    parameter int          DLY_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                macroscopic_pc,
    input  logic [31:0]                m_int_addr,
    input  logic [3:0]                 m_int_byteen,
    input  logic                       cfg_valid,
    input  logic [31:0]                cfg_pc,
    input  logic [DLY_W-1:0]           cfg_delay,
    output logic                       cfg_ready,
    output logic                       interrupt,
    output logic [$clog2(DEPTH):0]     pending_cnt,
    output logic [15:0]                ack_cnt,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DLY,
        S_ASSERT
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [31:0]      q_pc  [DEPTH];
    logic [DLY_W-1:0] q_dly [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             ack;
    logic             push;
    logic             pop;
    logic             more_left;

    // Full check uses the current count only: a pop in the same cycle does
    // not open a slot for a simultaneous push.
    assign cfg_ready = (pending_cnt < CW'(DEPTH));
    assign ack       = (m_int_addr[31:2] == BASE_ADDR[31:2]) && (m_int_byteen != 4'b0000);
    assign push      = cfg_valid && cfg_ready;
    assign pop       = (state == S_ASSERT) && ack;
    assign busy      = (state != S_IDLE);
    // Entries left after the pop, counting a push landing in the same cycle.
    assign more_left = (pending_cnt != CW'(1)) || push;

    // Event storage; a push never targets the head since it requires a free slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= cfg_pc;
            q_dly[wr_ptr] <= cfg_delay;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   pending_cnt <= pending_cnt + CW'(1);
                2'b01:   pending_cnt <= pending_cnt - CW'(1);
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

    // Event sequencer with registered interrupt and acknowledge counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            interrupt <= 1'b0;
            ack_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending_cnt != '0) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (macroscopic_pc == q_pc[rd_ptr]) begin
                        cnt   <= q_dly[rd_ptr];
                        state <= S_DLY;
                    end
                end
                S_DLY: begin
                    if (cnt == '0) begin
                        interrupt <= 1'b1;
                        state     <= S_ASSERT;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                S_ASSERT: begin
                    if (ack) begin
                        interrupt <= 1'b0;
                        if (ack_cnt != 16'hFFFF) ack_cnt <= ack_cnt + 16'd1;
                        state <= more_left ? S_ARMED : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/int_responder.md
Name: int_responder

Overview:
- Memory-mapped interrupt generator at the far end of the CPU's interrupt-generator port (m_int_addr / m_int_byteen).
- Holds a small queue of programmed interrupt events. Each event is armed on a macroscopic-PC match, waits a programmable delay, then raises `interrupt`.
- `interrupt` stays high until the CPU's handler acknowledges it with a store to the device address.
- Used in system-level benches and the FPGA top to exercise the exception/interrupt path of the pipelined CPU.

Parameters:
- BASE_ADDR, 32'h0000_7F20, word address of the acknowledge register; compare uses bits [31:2] only.
- DEPTH, 4, event-queue entries (power of two, ≥2).
- DLY_W, 8, width of the per-event delay field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- macroscopic_pc  in  32  CPU macroscopic PC
- m_int_addr  in  32  store address from CPU bridge
- m_int_byteen  in  4  store byte enables; nonzero means a write this cycle
- cfg_valid  in  1  event-load request
- cfg_pc  in  32  trigger PC of the event being loaded
- cfg_delay  in  DLY_W  cycles to wait after the PC match
- cfg_ready  out  1  queue can accept an event
- interrupt  out  1  interrupt request to CPU (registered)
- pending_cnt  out  $clog2(DEPTH)+1  queued events, including the active one
- ack_cnt  out  16  acknowledged interrupts, saturating at 16'hFFFF
- busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-event):
  - interrupt=0, queue emptied, pending_cnt=0, ack_cnt=0, state=IDLE, busy=0, cfg_ready=1.
  - The delay counter is cleared.
- Queue:
  - Circular FIFO with separate read and write pointers. Pointers wrap modulo DEPTH.
  - cfg_ready = (pending_cnt < DEPTH), computed from the current count.
  - A push occurs on `cfg_valid && cfg_ready`.
  - There is no pass-through: when full, a same-cycle pop does not free a slot for a same-cycle push.
  - Push and pop in the same cycle leave pending_cnt unchanged.
- ack condition: (m_int_addr[31:2] == BASE_ADDR[31:2]) && (m_int_byteen != 4'b0000).
  - byteen=0 is never an ack.
  - Any byte-lane pattern counts as an ack.
- State machine (head = oldest queue entry):
  - IDLE: if pending_cnt>0 then ARMED at the next edge.
  - ARMED: at an edge where macroscopic_pc == head.pc, load cnt=head.delay and go to DLY.
    - The PC compare is combinational on the current input.
    - Repeated PCs after the match are ignored.
  - DLY: if cnt==0, go to ASSERT and set interrupt=1 at the same edge; otherwise cnt decrements.
  - ASSERT: interrupt holds 1 until an ack is seen. On the ack edge:
    - interrupt=0.
    - Pop the head.
    - ack_cnt increments.
    - Next state is ARMED if remaining entries >0 (counting a same-cycle push), else IDLE.
- Timing:
  - PC match at edge t with delay D raises interrupt after edge t+1+D.
  - D=0 raises interrupt after edge t+1.
- Acks outside ASSERT are ignored:
  - no count change, no pop.
  - An ack in the same edge that enters ASSERT is also ignored.
- ack_cnt does not wrap. At 16'hFFFF it holds, while the pop still occurs.
- Pushes are accepted in every state.
- The active head is never overwritten before its pop.

Test Plan:
- Load {pc=0x3010, D=0}; drive PC 0x3000→0x3010 → interrupt rises one edge after the match edge. Store to 0x7F20 with byteen=4'b1111 → interrupt falls, ack_cnt=1, pending_cnt=0, busy=0.
- Load {0x3020, D=5}; match at edge t → interrupt first high after edge t+6. A store to 0x7F24 or with byteen=0 does not clear it. A store to 0x7F22 with byteen=4'b0100 clears it.
- Push 4 events → cfg_ready=0. 5th push rejected, pending_cnt=4. Events fire in load order; after 4 acks ack_cnt=4.
- Queue full, head in ASSERT; ack and cfg_valid in the same cycle → push rejected, pending_cnt=3.
- Ack store while ARMED or DLY → no effect. Assert reset mid-DLY (asynchronously, between edges) → interrupt=0, pending_cnt=0, cfg_ready=1 immediately.
- Back-to-back events {0x3000, D=0}, {0x3000, D=0} with PC held at 0x3000 → second interrupt rises one edge after the ack edge leads to ARMED and the match.
